// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and execution-stage FSM state encoding.
// The ALU control decoder imports the same op-code constants.
package alu_pkg;

    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_SLL     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SRL     = 4'b0101;
    localparam logic [3:0] OP_LUI     = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: holds the operand, the remaining count and the direction.
module alu_serial_shifter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic                   right_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] count_i,
    output logic [DATA_WIDTH-1:0]  shifted_o,
    output logic                   last_o
);

    logic [DATA_WIDTH-1:0]  data_q;
    logic [SHAMT_WIDTH-1:0] count_q;
    logic                   right_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
            right_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            count_q <= count_i;
            right_q <= right_i;
        end else if (shift_i) begin
            data_q  <= shifted_o;
            count_q <= count_q - SHAMT_WIDTH'(1);
        end
    end

    assign shifted_o = right_q ? (data_q >> 1) : (data_q << 1);
    // High on the step that takes the count to zero, so shifted_o is the final value.
    assign last_o    = (count_q == SHAMT_WIDTH'(1));

endmodule

// File: rtl/alu_iterative_exec.sv
// ALU execution stage: single-cycle logic/arith ops, serial shifts, registered result.
// Optional macro ALU_OVERFLOW_DETECT_EN enables signed overflow reporting on ADD/SUB.
module alu_iterative_exec
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  alu_data_o,
    output logic                   zero_o,
    output logic                   illegal_op_o,
    output logic                   overflow_o
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    state_e                state;
    state_e                next_state;
    logic                  is_shift_op;
    logic                  illegal_d;
    logic                  illegal_cap;
    logic                  shift_load;
    logic                  shift_en;
    logic                  capture;
    logic [DATA_WIDTH-1:0] op_result;
    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  last;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  zero_q;
    logic                  illegal_q;

    always_comb begin
        op_result   = '0;
        illegal_d   = 1'b0;
        is_shift_op = 1'b0;
        case (alu_operation_i)
            OP_ADD:  op_result = a_i + b_i;
            OP_SUB:  op_result = a_i - b_i;
            OP_OR:   op_result = a_i | b_i;
            OP_LUI:  op_result = b_i << 16;
            // A zero-length shift completes straight from IDLE with the unshifted operand.
            OP_SLL, OP_SRL: begin
                is_shift_op = 1'b1;
                op_result   = b_i;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        shift_load  = 1'b0;
        shift_en    = 1'b0;
        capture     = 1'b0;
        illegal_cap = 1'b0;
        result_d    = op_result;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    illegal_cap = illegal_d;
                    if (is_shift_op) begin
                        shift_load = 1'b1;
                        if (shamt_i == '0) begin
                            capture    = 1'b1;
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_SHIFT;
                        end
                    end else begin
                        capture    = 1'b1;
                        next_state = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                result_d = shifted;
                if (last) begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    alu_serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (shift_load),
        .shift_i   (shift_en),
        .right_i   (alu_operation_i == OP_SRL),
        .data_i    (b_i),
        .count_i   (shamt_i),
        .shifted_o (shifted),
        .last_o    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (capture) begin
            data_q    <= result_d;
            zero_q    <= (result_d == '0);
            illegal_q <= illegal_cap;
        end
    end

`ifdef ALU_OVERFLOW_DETECT_EN
    logic ovf_d;
    logic overflow_q;

    always_comb begin
        ovf_d = 1'b0;
        if (state == ST_IDLE) begin
            case (alu_operation_i)
                OP_ADD:  ovf_d = (a_i[MSB] == b_i[MSB]) && (op_result[MSB] != a_i[MSB]);
                OP_SUB:  ovf_d = (a_i[MSB] != b_i[MSB]) && (op_result[MSB] != a_i[MSB]);
                default: ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (capture) begin
            overflow_q <= ovf_d;
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign busy_o       = (state == ST_SHIFT) || (state == ST_DONE);
    assign done_o       = (state == ST_DONE);
    assign alu_data_o   = data_q;
    assign zero_o       = zero_q;
    assign illegal_op_o = illegal_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Self-checking bench for alu_iterative_exec: transaction-level model plus directed vectors.
module tb_alu_iterative_exec;

`ifdef ALU_OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  alu_operation_i = 4'b0000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] alu_data_o;
    logic        zero_o;
    logic        illegal_op_o;
    logic        overflow_o;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    alu_iterative_exec #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .alu_data_o      (alu_data_o),
        .zero_o          (zero_o),
        .illegal_op_o    (illegal_op_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: what one request must produce and how many edges it takes.
    typedef struct packed {
        logic [31:0] data;
        logic        ill;
        logic        ovf;
        int          lat;
    } exp_t;

    function automatic exp_t model_op(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint s;
        e.data = '0;
        e.ill  = 1'b0;
        e.ovf  = 1'b0;
        e.lat  = 1;
        case (op)
            4'b0011: begin
                e.data = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.ovf = OVF_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            4'b0100: begin
                e.data = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.ovf = OVF_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            4'b0001: e.data = a | b;
            4'b0110: e.data = {b[15:0], 16'h0000};
            4'b0010: begin e.data = b << sh; e.lat = int'(sh) + 1; end
            4'b0101: begin e.data = b >> sh; e.lat = int'(sh) + 1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    exp_t        nxt;
    logic        m_done = 1'b0;
    logic        in_flight = 1'b0;
    int          wait_left = 0;
    logic [31:0] m_data = '0;
    logic        m_ill = 1'b0;
    logic        m_ovf = 1'b0;
    exp_t        pend;

    always_comb nxt = model_op(alu_operation_i, a_i, b_i, shamt_i);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done    <= 1'b0;
            in_flight <= 1'b0;
            wait_left <= 0;
            m_data    <= '0;
            m_ill     <= 1'b0;
            m_ovf     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (in_flight) begin
                if (wait_left == 1) begin
                    in_flight <= 1'b0;
                    m_done    <= 1'b1;
                    m_data    <= pend.data;
                    m_ill     <= pend.ill;
                    m_ovf     <= pend.ovf;
                end
                wait_left <= wait_left - 1;
            end else if (!m_done && start_i) begin
                if (nxt.lat == 1) begin
                    m_done <= 1'b1;
                    m_data <= nxt.data;
                    m_ill  <= nxt.ill;
                    m_ovf  <= nxt.ovf;
                end else begin
                    in_flight <= 1'b1;
                    wait_left <= nxt.lat - 1;
                    pend      <= nxt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            check("cyc_done",    32'(done_o),       32'(m_done));
            check("cyc_busy",    32'(busy_o),       32'(in_flight | m_done));
            check("cyc_data",    alu_data_o,        m_data);
            check("cyc_zero",    32'(zero_o),       32'(m_data == '0));
            check("cyc_illegal", 32'(illegal_op_o), 32'(m_ill));
            check("cyc_ovf",     32'(overflow_o),   32'(m_ovf));
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat, output logic [31:0] data);
        @(negedge clk);
        #1;
        start_i = 1'b1;
        alu_operation_i = op;
        a_i = a;
        b_i = b;
        shamt_i = sh;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        alu_operation_i = 4'($urandom);
        a_i = $urandom;
        b_i = $urandom;
        shamt_i = 5'($urandom);
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) break;
            lat++;
        end
        data = alu_data_o;
    endtask

    task automatic hold_start(input int nedges, output int ndone);
        ndone = 0;
        @(negedge clk);
        #1;
        start_i = 1'b1;
        alu_operation_i = 4'b0010;
        a_i = 32'h0;
        b_i = 32'h5;
        shamt_i = 5'd3;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            start_i = (c + 1 < nedges);
            @(negedge clk);
            if (done_o) ndone++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          nd;
        logic [31:0] d;

        #12;
        check("rst_busy",    32'(busy_o),       32'd0);
        check("rst_done",    32'(done_o),       32'd0);
        check("rst_data",    alu_data_o,        32'd0);
        check("rst_zero",    32'(zero_o),       32'd1);
        check("rst_illegal", 32'(illegal_op_o), 32'd0);
        check("rst_ovf",     32'(overflow_o),   32'd0);
        reset = 1'b0;
        run_cmp = 1'b1;

        run_op(4'b0011, 32'd7, 32'd5, 5'd0, lat, d);
        check("add_lat", 32'(lat), 32'd1);
        check("add_data", d, 32'd12);
        check("add_zero", 32'(zero_o), 32'd0);

        run_op(4'b0100, 32'd5, 32'd5, 5'd0, lat, d);
        check("sub_data", d, 32'd0);
        check("sub_zero", 32'(zero_o), 32'd1);

        run_op(4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, d);
        check("addovf_data", d, 32'h8000_0000);
        check("addovf_flag", 32'(overflow_o), 32'(OVF_EN));

        run_op(4'b0100, 32'h8000_0000, 32'h1, 5'd0, lat, d);
        check("subovf_data", d, 32'h7FFF_FFFF);
        check("subovf_flag", 32'(overflow_o), 32'(OVF_EN));

        run_op(4'b0010, 32'h0, 32'h1, 5'd31, lat, d);
        check("sll31_lat", 32'(lat), 32'd32);
        check("sll31_data", d, 32'h8000_0000);

        run_op(4'b0101, 32'h0, 32'h8000_0000, 5'd4, lat, d);
        check("srl4_lat", 32'(lat), 32'd5);
        check("srl4_data", d, 32'h0800_0000);

        run_op(4'b0101, 32'h0, 32'h8000_0000, 5'd0, lat, d);
        check("srl0_lat", 32'(lat), 32'd1);
        check("srl0_data", d, 32'h8000_0000);

        run_op(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, lat, d);
        check("or_data", d, 32'hF0F0_0F0F);

        run_op(4'b1001, 32'h1234, 32'h5678, 5'd0, lat, d);
        check("ill_data", d, 32'd0);
        check("ill_flag", 32'(illegal_op_o), 32'd1);

        run_op(4'b1111, 32'h1, 32'h1, 5'd0, lat, d);
        check("ill15_flag", 32'(illegal_op_o), 32'd1);

        run_op(4'b0110, 32'h0, 32'h1234_ABCD, 5'd0, lat, d);
        check("lui_data", d, 32'hABCD_0000);
        check("lui_illegal", 32'(illegal_op_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            alu_operation_i = 4'b0011;
            a_i = $urandom;
            b_i = $urandom;
        end
        @(negedge clk);
        check("hold_data", alu_data_o, 32'hABCD_0000);

        hold_start(5, nd);
        check("hold5_pulses", 32'(nd), 32'd1);
        hold_start(6, nd);
        check("hold6_pulses", 32'(nd), 32'd2);
        check("hold6_data", alu_data_o, 32'd40);

        @(negedge clk);
        #1;
        start_i = 1'b1;
        alu_operation_i = 4'b0010;
        b_i = 32'h3;
        shamt_i = 5'd10;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy",    32'(busy_o),       32'd0);
        check("mid_rst_done",    32'(done_o),       32'd0);
        check("mid_rst_data",    alu_data_o,        32'd0);
        check("mid_rst_zero",    32'(zero_o),       32'd1);
        check("mid_rst_illegal", 32'(illegal_op_o), 32'd0);
        check("mid_rst_ovf",     32'(overflow_o),   32'd0);
        #1;
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        check("post_rst_pulses", 32'(nd), 32'd0);

        run_op(4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, d);
        check("wrap_data", d, 32'd0);
        check("wrap_zero", 32'(zero_o), 32'd1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Execution stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus operands, and produces the result, a zero flag and a completion handshake.
- Logic ops and add/sub complete in one cycle. Shifts run one bit per cycle through a serial shifter, which avoids a 32-bit barrel shifter.
- Sits between the register-file/immediate mux and the memory/write-back mux; the datapath holds the PC while busy_o is high.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount width; max shift is 2**SHAMT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request to execute; sampled only in IDLE.
- alu_operation_i  input  4  operation code from the ALU control decoder.
- a_i  input  DATA_WIDTH  operand A (rs).
- b_i  input  DATA_WIDTH  operand B (rt or immediate).
- shamt_i  input  SHAMT_WIDTH  shift amount.
- busy_o  output  1  high from the cycle after an accepted start until done.
- done_o  output  1  one-cycle pulse; alu_data_o is valid from this cycle.
- alu_data_o  output  DATA_WIDTH  registered result, held until the next completion.
- zero_o  output  1  high when alu_data_o == 0 (registered with the result).
- illegal_op_o  output  1  registered with the result; high if the code was not recognised.
- overflow_o  output  1  see Optional Feature.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy_o=0, done_o=0, alu_data_o=0, zero_o=1, illegal_op_o=0, overflow_o=0. An in-flight shift is abandoned and no done pulse is issued for it.
- Op codes and results:
  - 0011 ADD: a+b, mod 2^32.
  - 0100 SUB: a-b, mod 2^32.
  - 0001 OR: a|b.
  - 0110 LUI: {b[15:0],16'h0}.
  - 0010 SLL: b<<shamt.
  - 0101 SRL: b>>shamt, logical.
  - Any other code (including 1001): result 0, illegal_op_o=1.
- Operands and the op code are captured on the accepting edge. Input changes afterwards have no effect.
- State machine, IDLE:
  - If start_i=0, stay in IDLE.
  - If start_i=1 and the op is non-shift, compute and register the result, then go to DONE. Latency 1: done_o rises on the edge after acceptance.
  - If start_i=1 and the op is a shift: load the shift register with b_i and the counter with shamt_i.
    - Counter = 0: go to DONE.
    - Counter > 0: go to SHIFT.
- State machine, SHIFT:
  - Each cycle, shift one bit (left for SLL, right zero-fill for SRL) and decrement the counter.
  - When the counter reaches 0, register the result and go to DONE.
  - Latency is shamt+1 cycles from acceptance to done_o (shamt=0 gives 1, shamt=31 gives 32).
- State machine, DONE:
  - done_o=1 for exactly this cycle; return to IDLE next cycle.
  - start_i asserted in DONE is ignored. Minimum issue interval is 2 cycles.
- busy_o is high in SHIFT and DONE.
  - A start_i arriving while busy_o is high is dropped, not queued.
- The result, zero_o and illegal_op_o update only on completion. They are stable between completions.

Optional Feature:
- Macro: ALU_OVERFLOW_DETECT_EN.
- Defined: overflow_o is registered with the result.
  - ADD: set when a[31]==b[31] and res[31]!=a[31].
  - SUB: set when a[31]!=b[31] and res[31]!=a[31].
  - Other ops: 0.
- Undefined: overflow_o is tied 0 and no overflow logic is synthesised. The port remains present.

Decomposition:
- Shared package (alu_pkg): the 4-bit op-code constants (ADD 0011, OR 0001, SLL 0010, SUB 0100, SRL 0101, LUI 0110, ILLEGAL 1001) and the FSM state encoding.
  - The ALU control decoder uses the same op-code constants.
- Sub-module alu_serial_shifter contains:
  - the shift register and counter;
  - load/direction inputs;
  - a last_o flag for when the count reaches zero.

Test Plan:
- ADD: a=7, b=5, start for 1 cycle → next cycle done_o=1, alu_data_o=12, zero_o=0, busy_o=1 only during done.
- SUB: a=5, b=5 → result 0, zero_o=1.
  - With ALU_OVERFLOW_DETECT_EN, ADD a=0x7FFFFFFF, b=1 → result 0x80000000, overflow_o=1.
- SLL: b=0x1, shamt=31 → done_o exactly 32 cycles after acceptance, result 0x80000000.
- SRL: b=0x80000000, shamt=4 → result 0x08000000 after 5 cycles. Same op with shamt=0 → result 0x80000000 after 1 cycle.
- Busy and hold rules:
  - start_i held high through SLL shamt=3 → only one done pulse; the second request is accepted only from IDLE.
  - Result stays stable between completions.
- Bad op code and reset:
  - op=1001 → result 0, illegal_op_o=1.
  - Assert reset mid-SLL (cycle 2 of shamt=10) → all outputs go to reset values immediately, and no done pulse appears afterwards.
